req_xfer_split: RTL and testbench



---
 rtl/req_xfer_split_pkg.sv | 49 ++++
 rtl/req_xfer_split_calc.sv | 29 ++
 rtl/req_xfer_split.sv | 109 ++++++++++
 tb/tb_req_xfer_split.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/req_xfer_split_pkg.sv
// Shared request types for the request-path splitter: req_t layout, header
// subset, FSM states and helpers to pull apart and rebuild requests.
package req_xfer_split_pkg;

   localparam int VADDR_BITS    = 48;
   localparam int LEN_BITS      = 28;
   localparam int XFER_SIZE_DEF = 4096;

   typedef struct packed {
      logic [5:0]            pid;
      logic [3:0]            dest;
      logic [1:0]            strm;
      logic                  ctl;
      logic [LEN_BITS-1:0]   len;
      logic [VADDR_BITS-1:0] vaddr;
   } req_t;

   // Everything a chunk inherits from its parent request; ctl holds orig_ctl.
   typedef struct packed {
      logic [5:0] pid;
      logic [3:0] dest;
      logic [1:0] strm;
      logic       ctl;
   } hdr_t;

   typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

   function automatic hdr_t get_hdr(input req_t r);
      hdr_t h;
      h.pid  = r.pid;
      h.dest = r.dest;
      h.strm = r.strm;
      h.ctl  = r.ctl;
      return h;
   endfunction

   function automatic req_t make_req(input hdr_t h, input logic [VADDR_BITS-1:0] vaddr,
                                     input logic [LEN_BITS-1:0] len, input logic ctl);
      req_t r;
      r.pid   = h.pid;
      r.dest  = h.dest;
      r.strm  = h.strm;
      r.ctl   = ctl;
      r.len   = len;
      r.vaddr = vaddr;
      return r;
   endfunction

endpackage

// File: rtl/req_xfer_split_calc.sv
// Chunk arithmetic: how much of the remaining length fits before the next
// XFER_SIZE-aligned boundary, and where the following chunk starts.
module req_xfer_split_calc
   import req_xfer_split_pkg::*;
#(
   parameter int XFER_SIZE = XFER_SIZE_DEF
) (
   input  logic [VADDR_BITS-1:0] vaddr,
   input  logic [LEN_BITS-1:0]   rem_len,
   output logic [LEN_BITS-1:0]   clen,
   output logic                  last,
   output logic [VADDR_BITS-1:0] next_vaddr,
   output logic [LEN_BITS-1:0]   next_len
);

   localparam int LOG_XFER = $clog2(XFER_SIZE);

   // One extra bit so an aligned address yields room == XFER_SIZE exactly.
   logic [LEN_BITS:0] room;

   always_comb begin
      room       = (LEN_BITS+1)'(XFER_SIZE) - (LEN_BITS+1)'(vaddr[LOG_XFER-1:0]);
      last       = ({1'b0, rem_len} <= room);
      clen       = last ? rem_len : room[LEN_BITS-1:0];
      next_vaddr = vaddr + VADDR_BITS'(clen);
      next_len   = rem_len - clen;
   end

endmodule

// File: rtl/req_xfer_split.sv
// Splits one arbitrated request into chunks that never cross an XFER_SIZE
// boundary; ctl is carried only on the final chunk of each request.
module req_xfer_split
   import req_xfer_split_pkg::*;
#(
   parameter int XFER_SIZE = XFER_SIZE_DEF
) (
   input  logic aclk,
   input  logic areset,
   input  logic s_req_valid,
   output logic s_req_ready,
   input  req_t s_req_data,
   output logic m_req_valid,
   input  logic m_req_ready,
   output req_t m_req_data
);

   state_t                state;
   logic                  out_vld;
   req_t                  out_data;
   logic [VADDR_BITS-1:0] cur_vaddr;
   logic [LEN_BITS-1:0]   rem_len;
   hdr_t                  hdr;

   logic                  out_free;
   logic                  take;
   logic [VADDR_BITS-1:0] calc_vaddr;
   logic [LEN_BITS-1:0]   calc_len;
   hdr_t                  base_hdr;
   logic [LEN_BITS-1:0]   clen;
   logic                  last;
   logic [VADDR_BITS-1:0] next_vaddr;
   logic [LEN_BITS-1:0]   next_len;
   req_t                  chunk;

   // The IDLE path feeds the incoming request straight into the arithmetic so
   // the first chunk is registered on the handshake edge itself.
   always_comb begin
      out_free    = !out_vld || m_req_ready;
      s_req_ready = !areset && (state == ST_IDLE) && out_free;
      take        = s_req_valid && s_req_ready;
      if (state == ST_IDLE) begin
         calc_vaddr = s_req_data.vaddr;
         calc_len   = s_req_data.len;
         base_hdr   = get_hdr(s_req_data);
      end else begin
         calc_vaddr = cur_vaddr;
         calc_len   = rem_len;
         base_hdr   = hdr;
      end
      chunk = make_req(base_hdr, calc_vaddr, clen, base_hdr.ctl & last);
   end

   req_xfer_split_calc #(.XFER_SIZE(XFER_SIZE)) u_calc (
      .vaddr      (calc_vaddr),
      .rem_len    (calc_len),
      .clen       (clen),
      .last       (last),
      .next_vaddr (next_vaddr),
      .next_len   (next_len)
   );

   // NOTE: state uses non-blocking assignments only; a later assignment to
   // out_vld in the same edge deliberately overrides the handoff clear.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= ST_IDLE;
         out_vld   <= 1'b0;
         out_data  <= '0;
         cur_vaddr <= '0;
         rem_len   <= '0;
         hdr       <= '0;
      end else begin
         if (out_vld && m_req_ready)
            out_vld <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (take) begin
                  out_vld  <= 1'b1;
                  out_data <= chunk;
                  hdr      <= base_hdr;
                  if (!last) begin
                     cur_vaddr <= next_vaddr;
                     rem_len   <= next_len;
                     state     <= ST_SPLIT;
                  end
               end
            end
            ST_SPLIT: begin
               if (out_free) begin
                  out_vld  <= 1'b1;
                  out_data <= chunk;
                  if (last) begin
                     state <= ST_IDLE;
                  end else begin
                     cur_vaddr <= next_vaddr;
                     rem_len   <= next_len;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign m_req_valid = out_vld;
   assign m_req_data  = out_data;

endmodule

// File: tb/tb_req_xfer_split.sv
// Directed bench for req_xfer_split: hand-computed chunk sequences, stalls,
// boundary lengths, address wrap and asynchronous reset mid-sequence.
module tb_req_xfer_split;
   import req_xfer_split_pkg::*;

   logic aclk        = 1'b0;
   logic areset      = 1'b1;
   logic s_req_valid = 1'b0;
   logic m_req_ready = 1'b0;
   req_t s_req_data  = '0;
   logic s_req_ready;
   logic m_req_valid;
   req_t m_req_data;

   int checks = 0;
   int errors = 0;

   req_xfer_split #(.XFER_SIZE(4096)) dut (
      .aclk        (aclk),
      .areset      (areset),
      .s_req_valid (s_req_valid),
      .s_req_ready (s_req_ready),
      .s_req_data  (s_req_data),
      .m_req_valid (m_req_valid),
      .m_req_ready (m_req_ready),
      .m_req_data  (m_req_data)
   );

   always #5 aclk = ~aclk;

   function automatic req_t mk(input logic [VADDR_BITS-1:0] vaddr, input logic [LEN_BITS-1:0] len,
                               input logic ctl, input logic [5:0] pid);
      req_t r;
      r.pid   = pid;
      r.dest  = 4'h5;
      r.strm  = 2'h2;
      r.ctl   = ctl;
      r.len   = len;
      r.vaddr = vaddr;
      return r;
   endfunction

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_chunk(input string tag, input req_t expected);
      check({tag, "_valid"}, 128'(m_req_valid), 128'(1'b1));
      check({tag, "_data"}, 128'(m_req_data), 128'(expected));
   endtask

   task automatic check_idle_out(input string tag);
      check({tag, "_valid"}, 128'(m_req_valid), 128'(1'b0));
   endtask

   initial begin
      // Reset state while areset is held
      step();
      step();
      check("rst_m_valid", 128'(m_req_valid), 128'(1'b0));
      check("rst_m_data", 128'(m_req_data), 128'(0));
      check("rst_s_ready", 128'(s_req_ready), 128'(1'b0));
      areset = 1'b0;
      #1;
      check("post_rst_s_ready", 128'(s_req_ready), 128'(1'b1));

      // 1: aligned, len == XFER_SIZE -> single chunk
      m_req_ready = 1'b1;
      s_req_valid = 1'b1;
      s_req_data  = mk(48'h1000, 28'd4096, 1'b1, 6'h2A);
      step();
      s_req_valid = 1'b0;
      check_chunk("t1_c0", mk(48'h1000, 28'd4096, 1'b1, 6'h2A));
      check("t1_s_ready", 128'(s_req_ready), 128'(1'b1));
      step();
      check_idle_out("t1_done");

      // 2: crosses one boundary
      s_req_valid = 1'b1;
      s_req_data  = mk(48'h0F00, 28'h300, 1'b1, 6'h11);
      step();
      s_req_valid = 1'b0;
      check_chunk("t2_c0", mk(48'h0F00, 28'h100, 1'b0, 6'h11));
      check("t2_s_ready_split", 128'(s_req_ready), 128'(1'b0));
      step();
      check_chunk("t2_c1", mk(48'h1000, 28'h200, 1'b1, 6'h11));
      step();
      check_idle_out("t2_done");

      // 3: three chunks back-to-back, second request queued behind them
      s_req_valid = 1'b1;
      s_req_data  = mk(48'h0, 28'd10000, 1'b1, 6'h01);
      step();
      s_req_data  = mk(48'h7000, 28'h40, 1'b1, 6'h3C);
      check_chunk("t3_c0", mk(48'h0, 28'd4096, 1'b0, 6'h01));
      check("t3_s_ready_c0", 128'(s_req_ready), 128'(1'b0));
      step();
      check_chunk("t3_c1", mk(48'h1000, 28'd4096, 1'b0, 6'h01));
      check("t3_s_ready_c1", 128'(s_req_ready), 128'(1'b0));
      step();
      check_chunk("t3_c2", mk(48'h2000, 28'd1808, 1'b1, 6'h01));
      check("t3_s_ready_c2", 128'(s_req_ready), 128'(1'b1));
      step();
      s_req_valid = 1'b0;
      check_chunk("t3_next", mk(48'h7000, 28'h40, 1'b1, 6'h3C));
      step();
      check_idle_out("t3_done");

      // 4: zero length -> exactly one zero-length chunk
      s_req_valid = 1'b1;
      s_req_data  = mk(48'h1234, 28'd0, 1'b1, 6'h07);
      step();
      s_req_valid = 1'b0;
      check_chunk("t4_c0", mk(48'h1234, 28'd0, 1'b1, 6'h07));
      step();
      check_idle_out("t4_done0");
      step();
      check_idle_out("t4_done1");

      // 5: scenario 3 with a five-cycle stall on chunk 2
      s_req_valid = 1'b1;
      s_req_data  = mk(48'h0, 28'd10000, 1'b1, 6'h22);
      step();
      s_req_valid = 1'b0;
      check_chunk("t5_c0", mk(48'h0, 28'd4096, 1'b0, 6'h22));
      step();
      check_chunk("t5_c1", mk(48'h1000, 28'd4096, 1'b0, 6'h22));
      m_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_chunk("t5_stall", mk(48'h1000, 28'd4096, 1'b0, 6'h22));
         check("t5_stall_s_ready", 128'(s_req_ready), 128'(1'b0));
      end
      m_req_ready = 1'b1;
      step();
      check_chunk("t5_c2", mk(48'h2000, 28'd1808, 1'b1, 6'h22));
      step();
      check_idle_out("t5_done");

      // Address wrap at the top of the virtual address space
      s_req_valid = 1'b1;
      s_req_data  = mk(48'hFFFF_FFFF_F800, 28'h1000, 1'b1, 6'h15);
      step();
      s_req_valid = 1'b0;
      check_chunk("wrap_c0", mk(48'hFFFF_FFFF_F800, 28'h800, 1'b0, 6'h15));
      step();
      check_chunk("wrap_c1", mk(48'h0, 28'h800, 1'b1, 6'h15));
      step();
      check_idle_out("wrap_done");

      // 6: asynchronous reset during the second chunk of scenario 3
      s_req_valid = 1'b1;
      s_req_data  = mk(48'h0, 28'd10000, 1'b1, 6'h33);
      step();
      s_req_valid = 1'b0;
      check_chunk("t6_c0", mk(48'h0, 28'd4096, 1'b0, 6'h33));
      step();
      check_chunk("t6_c1", mk(48'h1000, 28'd4096, 1'b0, 6'h33));
      #2;
      areset = 1'b1;
      #1;
      check("t6_async_m_valid", 128'(m_req_valid), 128'(1'b0));
      check("t6_async_s_ready", 128'(s_req_ready), 128'(1'b0));
      step();
      check("t6_held_m_valid", 128'(m_req_valid), 128'(1'b0));
      check("t6_held_s_ready", 128'(s_req_ready), 128'(1'b0));
      areset = 1'b0;
      #1;
      check_idle_out("t6_released");
      s_req_valid = 1'b1;
      s_req_data  = mk(48'h5000, 28'd64, 1'b1, 6'h0C);
      step();
      s_req_valid = 1'b0;
      check_chunk("t6_new", mk(48'h5000, 28'd64, 1'b1, 6'h0C));
      step();
      check_idle_out("t6_no_remnant0");
      step();
      check_idle_out("t6_no_remnant1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
